// File: rtl/secure_access_gate_if.sv
// Request/response handshake bundle between a requester and the secure access gate.
// The master drives requests and accepts responses; the gate sits on the slave side.
interface secure_access_gate_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_priv;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_priv, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_priv, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/secure_access_gate.sv
// Permission-checked gate in front of a registered storage: one access at a time,
// checked against a lockable 4-region permission table, then issued or denied.
module secure_access_gate #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    secure_access_gate_if.slave bus,
    input  logic                cfg_we,
    input  logic                cfg_priv,
    input  logic [1:0]          cfg_region,
    input  logic [1:0]          cfg_perm,
    input  logic                cfg_lock,
    output logic                cfg_err,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_we,
    input  logic [DATA_W-1:0]   mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state, state_nxt;

    logic              ready_en;
    logic              wr_q;
    logic              priv_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [1:0]        perm [4];
    logic              lock;

    logic              req_ready_c;
    logic              rsp_valid_c;
    logic [DATA_W-1:0] rsp_rdata_c;
    logic              rsp_err_c;

    logic [1:0] region;
    logic       allowed;
    logic       accept;
    logic       cfg_ok;

    assign region  = addr_q[ADDR_W-1 -: 2];
    assign allowed = priv_q | (wr_q ? perm[region][0] : perm[region][1]);
    assign accept  = bus.req_valid & req_ready_c;
    assign cfg_ok  = cfg_priv & ~lock;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (accept) state_nxt = S_CHECK;
            S_CHECK: state_nxt = allowed ? S_ISSUE : S_RESP;
            S_ISSUE: state_nxt = wr_q ? S_RESP : S_WAIT;
            S_WAIT:  state_nxt = S_RESP;
            S_RESP:  if (bus.rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: every combinational output gets a default before the case, so no latch is inferred.
    always_comb begin
        req_ready_c = 1'b0;
        rsp_valid_c = 1'b0;
        rsp_rdata_c = '0;
        rsp_err_c   = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_we      = 1'b0;
        unique case (state)
            S_IDLE:  req_ready_c = ready_en;
            S_ISSUE: begin
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                mem_we    = wr_q;
            end
            S_WAIT: begin
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
            end
            S_RESP: begin
                rsp_valid_c = 1'b1;
                rsp_rdata_c = rdata_q;
                rsp_err_c   = err_q;
            end
            default: ;
        endcase
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_rdata = rsp_rdata_c;
    assign bus.rsp_err   = rsp_err_c;

    // ready_en keeps req_ready low until the first edge after reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en <= 1'b0;
            wr_q     <= 1'b0;
            priv_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (accept) begin
                wr_q    <= bus.req_write;
                priv_q  <= bus.req_priv;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
            if (state == S_CHECK && !allowed) err_q <= 1'b1;
            if (state == S_WAIT) rdata_q <= mem_rdata;
        end
    end

    // NOTE: the permission table is reset because deny-by-default must hold right after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) perm[i] <= 2'b00;
            lock    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we & ~cfg_ok;
            if (cfg_we && cfg_ok) begin
                perm[cfg_region] <= cfg_perm;
                if (cfg_lock) lock <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_secure_access_gate.sv
// Randomized self-checking bench for secure_access_gate: transaction-level reference
// model (permission rules, lock, word store) plus directed literal scenarios.
module tb_secure_access_gate;

    logic        clk;
    logic        rst;
    logic        cfg_we;
    logic        cfg_priv;
    logic [1:0]  cfg_region;
    logic [1:0]  cfg_perm;
    logic        cfg_lock;
    logic        cfg_err;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    secure_access_gate_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    secure_access_gate #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .cfg_we     (cfg_we),
        .cfg_priv   (cfg_priv),
        .cfg_region (cfg_region),
        .cfg_perm   (cfg_perm),
        .cfg_lock   (cfg_lock),
        .cfg_err    (cfg_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_val(input int a);
        logic [7:0] b;
        b = 8'(a);
        return {b, ~b, b ^ 8'h5A, 8'hC3};
    endfunction

    // Downstream storage: registered read, one edge after the address.
    logic [31:0] stor [256];
    bit          stor_ready = 1'b0;
    always @(posedge clk) begin
        if (!stor_ready) begin
            for (int i = 0; i < 256; i++) stor[i] <= init_val(i);
            stor_ready <= 1'b1;
        end else begin
            if (mem_we) stor[mem_addr] <= mem_wdata;
            mem_rdata <= stor[mem_addr];
        end
    end

    // Reference model: permission table, lock, expected config-error pulse.
    logic [1:0] m_perm [4];
    logic       m_lock;
    logic       exp_cfg_err = 1'b0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) m_perm[i] <= 2'b00;
            m_lock      <= 1'b0;
            exp_cfg_err <= 1'b0;
        end else if (cfg_we) begin
            if (cfg_priv && !m_lock) begin
                m_perm[cfg_region] <= cfg_perm;
                if (cfg_lock) m_lock <= 1'b1;
                exp_cfg_err <= 1'b0;
            end else begin
                exp_cfg_err <= 1'b1;
            end
        end else begin
            exp_cfg_err <= 1'b0;
        end
    end

    logic [31:0] ref_mem [256];
    logic        exp_we_ok = 1'b0;
    logic [7:0]  exp_mem_addr = '0;
    logic [31:0] exp_mem_wdata = '0;
    int          we_total = 0;

    // Per-cycle compare process.
    always @(negedge clk) begin
        if (!rst) begin
            check("cfg_err", {31'd0, cfg_err}, {31'd0, exp_cfg_err});
            check("ready_and_valid", {31'd0, bus.req_ready & bus.rsp_valid}, 32'd0);
            if (mem_we) begin
                we_total <= we_total + 1;
                check("mem_we_window", {31'd0, mem_we}, {31'd0, exp_we_ok});
                check("mem_addr", {24'd0, mem_addr}, {24'd0, exp_mem_addr});
                check("mem_wdata", mem_wdata, exp_mem_wdata);
            end
        end
    end

    task automatic cfg_write(input logic pr, input logic [1:0] rg, input logic [1:0] pm,
                             input logic lk, output logic o_err);
        cfg_we     = 1'b1;
        cfg_priv   = pr;
        cfg_region = rg;
        cfg_perm   = pm;
        cfg_lock   = lk;
        @(posedge clk);
        @(negedge clk);
        cfg_we = 1'b0;
        o_err  = cfg_err;
    endtask

    // One access, entered and left on a negedge; checks against the model.
    task automatic do_req(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                          input logic pr, input int hold, input logic cfg_mid,
                          output logic o_err, output logic [31:0] o_rdata, output int o_lat);
        int          w;
        int          lat;
        int          we_start;
        logic        allowed;
        logic        e_err;
        logic [31:0] e_rdata;
        int          e_lat;
        w = 0;
        while (!bus.req_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        check("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.req_priv  = pr;
        @(posedge clk);
        @(negedge clk);
        allowed  = pr || m_perm[addr[7:6]][wr ? 0 : 1];
        e_err    = !allowed;
        e_rdata  = (allowed && !wr) ? ref_mem[addr] : 32'd0;
        e_lat    = !allowed ? 1 : (wr ? 2 : 3);
        if (allowed && wr) ref_mem[addr] = wd;
        exp_we_ok     = allowed && wr;
        exp_mem_addr  = addr;
        exp_mem_wdata = wd;
        we_start      = we_total;
        // Requests presented while busy must be ignored.
        bus.req_valid = 1'($urandom_range(0, 1));
        bus.req_write = 1'($urandom_range(0, 1));
        bus.req_addr  = 8'($urandom);
        bus.req_wdata = $urandom;
        bus.req_priv  = 1'b1;
        if (cfg_mid) begin
            cfg_we     = 1'b1;
            cfg_priv   = ($urandom_range(0, 3) != 0);
            cfg_region = 2'($urandom_range(0, 3));
            cfg_perm   = 2'($urandom_range(0, 3));
            cfg_lock   = ($urandom_range(0, 31) == 0);
        end
        lat = 0;
        while (lat < 8) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            cfg_we = 1'b0;
            if (bus.rsp_valid) break;
        end
        check("latency", 32'(lat), 32'(e_lat));
        check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e_err});
        check("rsp_rdata", bus.rsp_rdata, e_rdata);
        o_err   = bus.rsp_err;
        o_rdata = bus.rsp_rdata;
        o_lat   = lat;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
            check("hold_err", {31'd0, bus.rsp_err}, {31'd0, e_err});
            check("hold_rdata", bus.rsp_rdata, e_rdata);
            check("hold_ready", {31'd0, bus.req_ready}, 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
        check("resp_exit_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("resp_exit_idle", {31'd0, bus.req_ready}, 32'd1);
        check("mem_we_count", 32'(we_total - we_start), (allowed && wr) ? 32'd1 : 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        e;
        logic [31:0] rd;
        int          lat;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        rst           = 1'b1;
        cfg_we        = 1'b0;
        cfg_priv      = 1'b0;
        cfg_region    = 2'd0;
        cfg_perm      = 2'd0;
        cfg_lock      = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_priv  = 1'b0;
        bus.rsp_ready = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
        check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        rst = 1'b0;
        #1 check("ready_after_release", {31'd0, bus.req_ready}, 32'd0);
        @(negedge clk);
        check("ready_first_edge", {31'd0, bus.req_ready}, 32'd1);

        // Deny-by-default read.
        do_req(1'b0, 8'h45, 32'd0, 1'b0, 0, 1'b0, e, rd, lat);
        check("lit_deny_lat", 32'(lat), 32'd1);
        check("lit_deny_err", {31'd0, e}, 32'd1);
        check("lit_deny_rdata", rd, 32'd0);

        // Open region 1, write then read back.
        cfg_write(1'b1, 2'd1, 2'b11, 1'b0, e);
        check("lit_cfg_ok", {31'd0, e}, 32'd0);
        do_req(1'b1, 8'h45, 32'hDEADBEEF, 1'b0, 0, 1'b0, e, rd, lat);
        check("lit_wr_lat", 32'(lat), 32'd2);
        check("lit_wr_err", {31'd0, e}, 32'd0);
        do_req(1'b0, 8'h45, 32'd0, 1'b0, 0, 1'b0, e, rd, lat);
        check("lit_rd_lat", 32'(lat), 32'd3);
        check("lit_rd_data", rd, 32'hDEADBEEF);

        // Unprivileged config rejected.
        cfg_write(1'b0, 2'd2, 2'b11, 1'b0, e);
        check("lit_cfg_unpriv", {31'd0, e}, 32'd1);

        // Privileged write to a closed region; response held for 5 cycles.
        do_req(1'b1, 8'hC3, 32'h1234_5678, 1'b1, 0, 1'b0, e, rd, lat);
        check("lit_priv_wr_err", {31'd0, e}, 32'd0);
        do_req(1'b0, 8'h45, 32'd0, 1'b0, 5, 1'b0, e, rd, lat);
        check("lit_hold_data", rd, 32'hDEADBEEF);

        // Random traffic with concurrent config writes.
        for (int n = 0; n < 160; n++) begin
            if ($urandom_range(0, 3) == 0)
                cfg_write(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                          2'($urandom_range(0, 3)), ($urandom_range(0, 63) == 0), e);
            do_req(1'($urandom_range(0, 1)), 8'($urandom), $urandom,
                   ($urandom_range(0, 3) == 0), $urandom_range(0, 3),
                   ($urandom_range(0, 2) == 0), e, rd, lat);
        end

        // Reset in the middle of WAIT.
        exp_we_ok     = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 8'h10;
        bus.req_priv  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 check("wait_mem_addr", {24'd0, mem_addr}, 32'h10);
        rst = 1'b1;
        #1;
        check("abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("abort_mem_we", {31'd0, mem_we}, 32'd0);
        check("abort_mem_addr", {24'd0, mem_addr}, 32'd0);
        check("abort_req_ready", {31'd0, bus.req_ready}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_resp_after_abort", {31'd0, bus.rsp_valid}, 32'd0);
        end
        do_req(1'b0, 8'h45, 32'd0, 1'b0, 0, 1'b0, e, rd, lat);
        check("lit_table_cleared", {31'd0, e}, 32'd1);

        // Lock: later config writes are rejected even when privileged.
        cfg_write(1'b1, 2'd0, 2'b11, 1'b1, e);
        check("lit_lock_accept", {31'd0, e}, 32'd0);
        cfg_write(1'b1, 2'd2, 2'b11, 1'b0, e);
        check("lit_locked_reject", {31'd0, e}, 32'd1);
        do_req(1'b0, 8'h80, 32'd0, 1'b0, 0, 1'b0, e, rd, lat);
        check("lit_region2_closed", {31'd0, e}, 32'd1);
        do_req(1'b0, 8'h05, 32'd0, 1'b0, 0, 1'b0, e, rd, lat);
        check("lit_region0_open", {31'd0, e}, 32'd0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
